// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    localparam logic [15:0] HALT_OPCODE = 16'hFFFF;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO: synchronous clear, push, pop, head word, occupancy count.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Pointers are log2(DEPTH) wide, so they wrap for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC-driven issue, prefetch buffer, flush redirect.
// Optional HALT support is compiled in with `define FETCH_HALT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int INSTR_WIDTH = 16,
    parameter int BUF_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic [ADDR_WIDTH-1:0]  pcIn,
    output logic                   pcIncEn,
    output logic                   pcWrEn,
    output logic [ADDR_WIDTH-1:0]  pcWrData,
    output logic                   memRdEn,
    output logic [ADDR_WIDTH-1:0]  memAddr,
    input  logic [INSTR_WIDTH-1:0] memData,
    output logic [INSTR_WIDTH-1:0] instrOut,
    output logic                   instrValid,
    input  logic                   instrReady,
    input  logic                   flush,
    input  logic [ADDR_WIDTH-1:0]  flushAddr
);
    localparam int CW = cnt_w(BUF_DEPTH);

    fetch_state_e  state;
    logic          in_flight;
    logic [CW-1:0] count;
    logic          buf_full;
    logic          buf_empty;
    logic          flush_act;
    logic          pop;
    logic          push;
    logic          issue;
    logic          halt_hit;
    logic [CW:0]   occ;
    logic [CW:0]   lim;

    assign flush_act  = flush && (state != ST_RESET);
    assign instrValid = !buf_empty && !flush_act;
    assign pop        = instrValid && instrReady;

    // A returning read is dropped on flush or once halted.
    assign push = in_flight && !flush_act && (state != ST_HALTED) && (!buf_full || pop);

    // count + inFlight - pop < BUF_DEPTH, rearranged to stay unsigned.
    assign occ   = {1'b0, count} + (CW+1)'(in_flight);
    assign lim   = (CW+1)'(BUF_DEPTH) + (CW+1)'(pop);
    assign issue = ((state == ST_RUN) || (state == ST_FLUSH)) && !flush_act && (occ < lim);

    assign memRdEn  = issue;
    assign memAddr  = pcIn;
    assign pcIncEn  = issue;
    assign pcWrEn   = flush_act;
    assign pcWrData = flush_act ? flushAddr : '0;

`ifdef FETCH_HALT_EN
    assign halt_hit = push && (memData == HALT_OPCODE);
`else
    assign halt_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= ST_RESET;
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
            if (flush_act) begin
                state <= ST_FLUSH;
            end else begin
                case (state)
                    ST_RESET:  state <= ST_RUN;
                    ST_RUN:    state <= halt_hit ? ST_HALTED : ST_RUN;
                    ST_FLUSH:  state <= halt_hit ? ST_HALTED : ST_RUN;
                    ST_HALTED: state <= ST_HALTED;
                    default:   state <= ST_RESET;
                endcase
            end
        end
    end

    fetch_buffer #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rstN),
        .clear (flush_act),
        .push  (push),
        .din   (memData),
        .pop   (pop),
        .head  (instrOut),
        .count (count),
        .full  (buf_full),
        .empty (buf_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC/memory models plus an expected-stream model.
module tb_fetch_unit;

    logic        clk;
    logic        rstN;
    logic [11:0] pcIn;
    logic        pcIncEn;
    logic        pcWrEn;
    logic [11:0] pcWrData;
    logic        memRdEn;
    logic [11:0] memAddr;
    logic [15:0] memData;
    logic [15:0] instrOut;
    logic        instrValid;
    logic        instrReady;
    logic        flush;
    logic [11:0] flushAddr;

    int          tests;
    int          fails;
    int          delivered;
    int          issues;
    logic [11:0] exp_addr;
    bit          halt_mode;
    bit          seen_halt;

    fetch_unit dut (
        .clk        (clk),
        .rstN       (rstN),
        .pcIn       (pcIn),
        .pcIncEn    (pcIncEn),
        .pcWrEn     (pcWrEn),
        .pcWrData   (pcWrData),
        .memRdEn    (memRdEn),
        .memAddr    (memAddr),
        .memData    (memData),
        .instrOut   (instrOut),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .flush      (flush),
        .flushAddr  (flushAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [11:0] a);
        if (halt_mode && a == 12'd3) return 16'hFFFF;
        return {4'h0, a} + 16'h1000;
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN)        pcIn <= '0;
        else if (pcWrEn)  pcIn <= pcWrData;
        else if (pcIncEn) pcIn <= pcIn + 12'd1;
    end

    always @(posedge clk) begin
        if (memRdEn) memData <= mem_val(memAddr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge; maintain the expected in-order word stream.
    task automatic observe();
        @(negedge clk);
        check("excl_inc_wr", 32'(pcIncEn & pcWrEn), 0);
        if (rstN && flush) begin
            check("flush_valid", 32'(instrValid), 0);
            check("flush_wren", 32'(pcWrEn), 1);
            check("flush_wrdata", 32'(pcWrData), 32'(flushAddr));
            check("flush_noinc", 32'(pcIncEn), 0);
            exp_addr  = flushAddr;
            seen_halt = 1'b0;
        end else if (instrValid && instrReady) begin
            check("stream", 32'(instrOut), 32'(mem_val(exp_addr)));
            if (halt_mode && instrOut == 16'hFFFF) seen_halt = 1'b1;
            exp_addr  = exp_addr + 12'd1;
            delivered++;
        end
        if (memRdEn) issues++;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstN      = 1'b0;
        flush     = 1'b0;
        exp_addr  = '0;
        seen_halt = 1'b0;
        observe();
        check("rst_inc", 32'(pcIncEn), 0);
        check("rst_wren", 32'(pcWrEn), 0);
        check("rst_wrdata", 32'(pcWrData), 0);
        check("rst_rden", 32'(memRdEn), 0);
        check("rst_addr", 32'(memAddr), 32'(pcIn));
        check("rst_out", 32'(instrOut), 0);
        check("rst_valid", 32'(instrValid), 0);
        advance();
        rstN   = 1'b1;
        issues = 0;
    endtask

    // Cycle 0 = first cycle with rstN high: issue from cycle 1, valid from cycle 3.
    task automatic startup();
        for (int c = 0; c < 6; c++) begin
            observe();
            check("st_rden", 32'(memRdEn), 32'(c >= 1));
            check("st_addr", 32'(memAddr), 32'(pcIn));
            check("st_valid", 32'(instrValid), 32'(c >= 3));
            if (c >= 3) check("st_word", 32'(instrOut), 32'h1000 + 32'(c - 3));
            advance();
        end
    endtask

    initial begin
        tests = 0; fails = 0; delivered = 0; issues = 0;
        halt_mode  = 1'b0;
        rstN       = 1'b0;
        instrReady = 1'b1;
        flush      = 1'b0;
        flushAddr  = '0;
        exp_addr   = '0;
        seen_halt  = 1'b0;

        // Reset release with decode always ready.
        do_reset();
        startup();

        // Decode stalled: two issues fill the buffer, then fetch stops.
        do_reset();
        instrReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            observe();
            check("stall_rden", 32'(memRdEn), 32'(c == 1 || c == 2));
            advance();
        end
        check("stall_issues", 32'(issues), 2);
        observe();
        check("stall_valid", 32'(instrValid), 1);
        check("stall_head", 32'(instrOut), 32'h1000);
        check("stall_pc", 32'(pcIn), 2);
        check("stall_rden2", 32'(memRdEn), 0);
        advance();

        // One pop with an issue in flight, then redirect to 0x080.
        instrReady = 1'b1;
        observe();
        check("pre_fl_rden", 32'(memRdEn), 1);
        advance();
        flush = 1'b1; flushAddr = 12'h080;
        observe();
        check("fl_rden", 32'(memRdEn), 0);
        advance();
        flush = 1'b0;
        observe();
        check("fl1_rden", 32'(memRdEn), 1);
        check("fl1_addr", 32'(memAddr), 32'h080);
        advance();
        observe();
        check("fl2_valid", 32'(instrValid), 0);
        advance();
        observe();
        check("fl3_valid", 32'(instrValid), 1);
        check("fl3_word", 32'(instrOut), 32'h1080);
        advance();
        for (int c = 0; c < 4; c++) begin observe(); advance(); end

        // Reset dropped mid-stream for one cycle.
        do_reset();
        startup();

        // Random decode backpressure with occasional redirects.
        delivered = 0;
        for (int c = 0; c < 200; c++) begin
            instrReady = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                flush     = 1'b1;
                flushAddr = 12'($urandom_range(0, 4095));
            end else begin
                flush = 1'b0;
            end
            observe();
            advance();
        end
        flush = 1'b0;
        check("rand_progress", 32'(delivered > 40), 1);

`ifdef FETCH_HALT_EN
        halt_mode  = 1'b1;
        instrReady = 1'b1;
        do_reset();
        delivered = 0;
        for (int c = 0; c < 15; c++) begin
            observe();
            if (seen_halt) check("halt_rden", 32'(memRdEn), 0);
            advance();
        end
        check("halt_count", 32'(delivered), 4);
        check("halt_seen", 32'(seen_halt), 1);
        flush = 1'b1; flushAddr = 12'h010;
        observe();
        advance();
        flush = 1'b0;
        delivered = 0;
        for (int c = 0; c < 6; c++) begin observe(); advance(); end
        check("halt_resume", 32'(delivered >= 3), 1);
        halt_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
